// File: rtl/fir_complex_pkg.sv
// Shared constants, types, coefficient tables and fixed-point helper for fir_complex.
// Imag coefficients only take effect when FIR_COMPLEX_IMAG_COEFF_EN is defined.
package fir_complex_pkg;

    localparam int DATA_SIZE  = 32;
    localparam int TAPS       = 20;
    localparam int QUANT_BITS = 10;
    localparam int PROD_SIZE  = 2 * DATA_SIZE;

    typedef logic signed [DATA_SIZE-1:0] sample_t;
    typedef logic signed [PROD_SIZE-1:0] prod_t;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Symmetric low-pass channel filter, QUANT_BITS fraction bits.
    localparam sample_t CHANNEL_COEFFS_REAL [TAPS] = '{
        32'sh001,  32'sh008, -32'sh00d,  32'sh009,  32'sh00b,
        -32'sh02d, 32'sh045, -32'sh02d, -32'sh04f,  32'sh257,
        32'sh257, -32'sh04f, -32'sh02d,  32'sh045, -32'sh02d,
        32'sh00b,  32'sh009, -32'sh00d,  32'sh008,  32'sh001
    };

    localparam sample_t CHANNEL_COEFFS_IMAG [TAPS] = '{default: '0};

    // Divide by 2^QUANT_BITS rounding toward zero, keep DATA_SIZE bits.
    function automatic sample_t deq(input prod_t p);
        prod_t biased;
        biased = p[PROD_SIZE-1] ? p + prod_t'((1 << QUANT_BITS) - 1) : p;
        return sample_t'(biased >>> QUANT_BITS);
    endfunction

endpackage

// File: rtl/fir_complex_if.sv
// I/Q sample and result FIFO bus of fir_complex, plus the FSM state for observation.
// slave is the filter side, master is the front end / demodulator side.
interface fir_complex_if;
    import fir_complex_pkg::*;

    sample_t xreal_in_din;
    logic    xreal_in_wr_en;
    logic    xreal_in_full;
    sample_t ximag_in_din;
    logic    ximag_in_wr_en;
    logic    ximag_in_full;
    sample_t yreal_out_dout;
    logic    yreal_out_rd_en;
    logic    yreal_out_empty;
    sample_t yimag_out_dout;
    logic    yimag_out_rd_en;
    logic    yimag_out_empty;
    state_t  fsm_state;

    // Push on wr_en && !full, pop on rd_en && !empty; dout valid while !empty.
    modport slave (
        input  xreal_in_din, xreal_in_wr_en, ximag_in_din, ximag_in_wr_en,
        input  yreal_out_rd_en, yimag_out_rd_en,
        output xreal_in_full, ximag_in_full,
        output yreal_out_dout, yreal_out_empty, yimag_out_dout, yimag_out_empty,
        output fsm_state
    );

    modport master (
        output xreal_in_din, xreal_in_wr_en, ximag_in_din, ximag_in_wr_en,
        output yreal_out_rd_en, yimag_out_rd_en,
        input  xreal_in_full, ximag_in_full,
        input  yreal_out_dout, yreal_out_empty, yimag_out_dout, yimag_out_empty,
        input  fsm_state
    );

endinterface

// File: rtl/fir_complex_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head combinationally, 0 while empty.
module fir_complex_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    input  logic             rd_en,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dout is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fir_complex.sv
// Complex decimating FIR: pops DECIMATION I/Q pairs, runs one tap per cycle, pushes one result pair.
// Define FIR_COMPLEX_IMAG_COEFF_EN to build the full complex multiply with imaginary taps.
module fir_complex
    import fir_complex_pkg::*;
#(
    parameter int DECIMATION = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clock,
    input  logic reset,
    fir_complex_if.slave bus
);
    localparam int TW = $clog2(TAPS);
    localparam int CW = $clog2(DECIMATION + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  load_cnt_q, load_cnt_d;
    logic [TW-1:0]  tap_q, tap_d;
    sample_t        hist_r_q [TAPS];
    sample_t        hist_r_d [TAPS];
    sample_t        hist_i_q [TAPS];
    sample_t        hist_i_d [TAPS];
    sample_t        acc_r_q, acc_r_d;
    sample_t        acc_i_q, acc_i_d;

    logic           pop_in, push_out;
    logic           xr_empty, xi_empty, yr_full, yi_full;
    logic [DATA_SIZE-1:0] xr_dout, xi_dout;

    sample_t        x_r, x_i, h_r;
    prod_t          prod_r, prod_i;

    fir_complex_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_xreal_fifo (
        .clock(clock), .reset(reset),
        .din(bus.xreal_in_din), .wr_en(bus.xreal_in_wr_en), .full(bus.xreal_in_full),
        .dout(xr_dout), .rd_en(pop_in), .empty(xr_empty)
    );

    fir_complex_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_ximag_fifo (
        .clock(clock), .reset(reset),
        .din(bus.ximag_in_din), .wr_en(bus.ximag_in_wr_en), .full(bus.ximag_in_full),
        .dout(xi_dout), .rd_en(pop_in), .empty(xi_empty)
    );

    fir_complex_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_yreal_fifo (
        .clock(clock), .reset(reset),
        .din(acc_r_q), .wr_en(push_out), .full(yr_full),
        .dout(bus.yreal_out_dout), .rd_en(bus.yreal_out_rd_en), .empty(bus.yreal_out_empty)
    );

    fir_complex_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_yimag_fifo (
        .clock(clock), .reset(reset),
        .din(acc_i_q), .wr_en(push_out), .full(yi_full),
        .dout(bus.yimag_out_dout), .rd_en(bus.yimag_out_rd_en), .empty(bus.yimag_out_empty)
    );

    assign bus.fsm_state = state_q;

    assign x_r = hist_r_q[tap_q];
    assign x_i = hist_i_q[tap_q];
    assign h_r = CHANNEL_COEFFS_REAL[tap_q];

`ifdef FIR_COMPLEX_IMAG_COEFF_EN
    sample_t h_i;
    assign h_i    = CHANNEL_COEFFS_IMAG[tap_q];
    assign prod_r = prod_t'(x_r) * prod_t'(h_r) - prod_t'(x_i) * prod_t'(h_i);
    assign prod_i = prod_t'(x_r) * prod_t'(h_i) + prod_t'(x_i) * prod_t'(h_r);
`else
    assign prod_r = prod_t'(x_r) * prod_t'(h_r);
    assign prod_i = prod_t'(x_i) * prod_t'(h_r);
`endif

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        tap_d      = tap_q;
        hist_r_d   = hist_r_q;
        hist_i_d   = hist_i_q;
        acc_r_d    = acc_r_q;
        acc_i_d    = acc_i_q;
        pop_in     = 1'b0;
        push_out   = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (!xr_empty && !xi_empty) begin
                    pop_in = 1'b1;
                    for (int k = TAPS - 1; k > 0; k--) begin
                        hist_r_d[k] = hist_r_q[k-1];
                        hist_i_d[k] = hist_i_q[k-1];
                    end
                    hist_r_d[0] = xr_dout;
                    hist_i_d[0] = xi_dout;
                    if (load_cnt_q == CW'(DECIMATION - 1)) begin
                        load_cnt_d = '0;
                        tap_d      = '0;
                        acc_r_d    = '0;
                        acc_i_d    = '0;
                        state_d    = S_MAC;
                    end else begin
                        load_cnt_d = load_cnt_q + CW'(1);
                    end
                end
            end
            S_MAC: begin
                acc_r_d = acc_r_q + deq(prod_r);
                acc_i_d = acc_i_q + deq(prod_i);
                if (tap_q == TW'(TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    tap_d = tap_q + TW'(1);
                end
            end
            S_WRITE: begin
                // Both output FIFOs are written together so I/Q stay paired.
                if (!yr_full && !yi_full) begin
                    push_out = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_LOAD;
            load_cnt_q <= '0;
            tap_q      <= '0;
            hist_r_q   <= '{default: '0};
            hist_i_q   <= '{default: '0};
            acc_r_q    <= '0;
            acc_i_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            tap_q      <= tap_d;
            hist_r_q   <= hist_r_d;
            hist_i_q   <= hist_i_d;
            acc_r_q    <= acc_r_d;
            acc_i_q    <= acc_i_d;
        end
    end

endmodule

// File: tb/tb_fir_complex.sv
// Scoreboard bench for fir_complex: one DECIMATION=1 instance and one DECIMATION=4 instance.
module tb_fir_complex;
    import fir_complex_pkg::*;

    localparam int W  = 32;
    localparam int NT = 20;
    localparam int H_R [NT] = '{1, 8, -13, 9, 11, -45, 69, -45, -79, 599,
                                599, -79, -45, 69, -45, 11, 9, -13, 8, 1};

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fir_complex_if bus1 ();
    fir_complex_if bus4 ();

    fir_complex #(.DECIMATION(1), .FIFO_DEPTH(16)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));
    fir_complex #(.DECIMATION(4), .FIFO_DEPTH(16)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));

    int tests  = 0;
    int failed = 0;
    logic mon_en = 1'b0;

    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] exp4_q [$];

    int m1_r [NT];
    int m1_i [NT];
    int m4_r [NT];
    int m4_i [NT];
    int m4_cnt = 0;

    // Reference: truncating integer division, 32-bit wrapping accumulation.
    function automatic logic [2*W-1:0] fir_ref(input int xr [NT], input int xi [NT]);
        int ar, ai;
        ar = 0;
        ai = 0;
        for (int k = 0; k < NT; k++) begin
            ar += int'((longint'(xr[k]) * longint'(H_R[k])) / 64'sd1024);
            ai += int'((longint'(xi[k]) * longint'(H_R[k])) / 64'sd1024);
        end
        return {ar, ai};
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model1_clear();
        for (int k = 0; k < NT; k++) begin
            m1_r[k] = 0;
            m1_i[k] = 0;
        end
        exp_q.delete();
    endtask

    task automatic send1(input int xr, input int xi);
        int n = 0;
        while ((bus1.xreal_in_full || bus1.ximag_in_full) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            tests++;
            failed++;
            $display("FAIL send1_timeout got=full exp=space");
        end
        bus1.xreal_in_din   = xr;
        bus1.ximag_in_din   = xi;
        bus1.xreal_in_wr_en = 1'b1;
        bus1.ximag_in_wr_en = 1'b1;
        @(negedge clock);
        bus1.xreal_in_wr_en = 1'b0;
        bus1.ximag_in_wr_en = 1'b0;
        for (int k = NT - 1; k > 0; k--) begin
            m1_r[k] = m1_r[k-1];
            m1_i[k] = m1_i[k-1];
        end
        m1_r[0] = xr;
        m1_i[0] = xi;
        exp_q.push_back(fir_ref(m1_r, m1_i));
    endtask

    task automatic send4(input int xr, input int xi);
        int n = 0;
        while ((bus4.xreal_in_full || bus4.ximag_in_full) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            tests++;
            failed++;
            $display("FAIL send4_timeout got=full exp=space");
        end
        bus4.xreal_in_din   = xr;
        bus4.ximag_in_din   = xi;
        bus4.xreal_in_wr_en = 1'b1;
        bus4.ximag_in_wr_en = 1'b1;
        @(negedge clock);
        bus4.xreal_in_wr_en = 1'b0;
        bus4.ximag_in_wr_en = 1'b0;
        for (int k = NT - 1; k > 0; k--) begin
            m4_r[k] = m4_r[k-1];
            m4_i[k] = m4_i[k-1];
        end
        m4_r[0] = xr;
        m4_i[0] = xi;
        m4_cnt++;
        if (m4_cnt == 4) begin
            m4_cnt = 0;
            exp4_q.push_back(fir_ref(m4_r, m4_i));
        end
    endtask

    task automatic wait_drain(input string name, input bit dec4);
        int n = 0;
        while (((dec4 ? exp4_q.size() : exp_q.size()) != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            tests++;
            failed++;
            $display("FAIL %s_drain_timeout got=%0d pending exp=0", name,
                     dec4 ? exp4_q.size() : exp_q.size());
        end
    endtask

    // Monitors: compare the head at the falling edge, pop it on the next rising edge.
    always @(negedge clock) begin
        bus1.yreal_out_rd_en = 1'b0;
        bus1.yimag_out_rd_en = 1'b0;
        if (reset && mon_en && !bus1.yreal_out_empty) begin
            check("dut1_lockstep_empty", {63'd0, bus1.yimag_out_empty}, 64'd0);
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL dut1_unexpected got=%h exp=none", {bus1.yreal_out_dout, bus1.yimag_out_dout});
            end else begin
                check("dut1_out", {bus1.yreal_out_dout, bus1.yimag_out_dout}, exp_q.pop_front());
            end
            bus1.yreal_out_rd_en = 1'b1;
            bus1.yimag_out_rd_en = 1'b1;
        end
    end

    always @(negedge clock) begin
        bus4.yreal_out_rd_en = 1'b0;
        bus4.yimag_out_rd_en = 1'b0;
        if (reset && !bus4.yreal_out_empty) begin
            check("dut4_lockstep_empty", {63'd0, bus4.yimag_out_empty}, 64'd0);
            if (exp4_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL dut4_unexpected got=%h exp=none", {bus4.yreal_out_dout, bus4.yimag_out_dout});
            end else begin
                check("dut4_out", {bus4.yreal_out_dout, bus4.yimag_out_dout}, exp4_q.pop_front());
            end
            bus4.yreal_out_rd_en = 1'b1;
            bus4.yimag_out_rd_en = 1'b1;
        end
    end

    localparam int NEG_R [8] = '{-1, -1025, 1025, 7, 32'h7fffffff, 32'h80000000, -3, 1023};
    localparam int NEG_I [8] = '{-1, 1025, -1025, -3, 32'h80000000, 32'h7fffffff, 5, -1023};

    initial begin
        bus1.xreal_in_din = '0; bus1.ximag_in_din = '0;
        bus1.xreal_in_wr_en = 1'b0; bus1.ximag_in_wr_en = 1'b0;
        bus4.xreal_in_din = '0; bus4.ximag_in_din = '0;
        bus4.xreal_in_wr_en = 1'b0; bus4.ximag_in_wr_en = 1'b0;
        model1_clear();
        for (int k = 0; k < NT; k++) begin
            m4_r[k] = 0;
            m4_i[k] = 0;
        end

        repeat (3) @(negedge clock);
        check("rst_yreal_empty", {63'd0, bus1.yreal_out_empty}, 64'd1);
        check("rst_yimag_empty", {63'd0, bus1.yimag_out_empty}, 64'd1);
        check("rst_xreal_full", {63'd0, bus1.xreal_in_full}, 64'd0);
        check("rst_ximag_full", {63'd0, bus1.ximag_in_full}, 64'd0);
        check("rst_dout", {bus1.yreal_out_dout, bus1.yimag_out_dout}, 64'd0);
        check("rst_state", 64'(bus1.fsm_state), 64'(S_LOAD));
        reset = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;

        // Impulse on I then on Q: each output equals one tap.
        send1(32'h400, 0);
        repeat (19) send1(0, 0);
        send1(0, 32'h400);
        repeat (19) send1(0, 0);
        wait_drain("impulse", 1'b0);

        // Step: ramps up, then settles at sum of taps (0x406).
        repeat (40) send1(32'h400, 32'h400);
        wait_drain("step", 1'b0);

        // Odd products with negative signs and full-scale inputs.
        for (int r = 0; r < 3; r++)
            for (int v = 0; v < 8; v++) send1(NEG_R[v], NEG_I[v]);
        repeat (20) send1(0, 0);
        wait_drain("trunc", 1'b0);

        // Backpressure: no reads until outputs and inputs are all full.
        mon_en = 1'b0;
        for (int v = 0; v < 33; v++) send1(v * 32'h100 - 32'h1000, 32'h800 - v * 32'h40);
        repeat (60) @(negedge clock);
        check("bp_xreal_full", {63'd0, bus1.xreal_in_full}, 64'd1);
        check("bp_ximag_full", {63'd0, bus1.ximag_in_full}, 64'd1);
        check("bp_yreal_empty", {63'd0, bus1.yreal_out_empty}, 64'd0);
        check("bp_yimag_empty", {63'd0, bus1.yimag_out_empty}, 64'd0);
        check("bp_state", 64'(bus1.fsm_state), 64'(S_WRITE));
        mon_en = 1'b1;
        wait_drain("backpressure", 1'b0);

        // Decimate by 4: 16 pairs give exactly 4 results.
        for (int v = 1; v <= 16; v++) send4(v * 32'h400, -v * 32'h200);
        wait_drain("dec4", 1'b1);
        repeat (50) @(negedge clock);
        check("dec4_no_extra", {63'd0, bus4.yreal_out_empty}, 64'd1);

        // Reset while a MAC is in progress with results still queued.
        mon_en = 1'b0;
        send1(32'h400, 32'h400);
        send1(32'h800, 0);
        repeat (50) @(negedge clock);
        send1(32'h400, 0);
        repeat (5) @(negedge clock);
        check("pre_rst_state", 64'(bus1.fsm_state), 64'(S_MAC));
        check("pre_rst_yreal_empty", {63'd0, bus1.yreal_out_empty}, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_yreal_empty", {63'd0, bus1.yreal_out_empty}, 64'd1);
        check("mid_rst_yimag_empty", {63'd0, bus1.yimag_out_empty}, 64'd1);
        check("mid_rst_xreal_full", {63'd0, bus1.xreal_in_full}, 64'd0);
        check("mid_rst_state", 64'(bus1.fsm_state), 64'(S_LOAD));
        model1_clear();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;
        send1(32'h400, 32'h400);
        repeat (19) send1(0, 0);
        wait_drain("post_reset", 1'b0);
        repeat (30) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
